if_id_skid_stage: RTL

Parametrised IF/ID pipeline stage with a two-entry skid buffer and a valid/ready handshake on both sides. It sits between instruction fetch and decode. It replaces fixed write-enable/flush latching with full backpressure, one-per-cycle throughput, synchronous flush with NOP injection, and an optional decoded-field output.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/instr_field_split.sv | 20 ++
 rtl/if_id_skid_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID skid stage: occupancy states,
// the default bubble word and MIPS field positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SA_MSB     = 10;
    localparam int SA_LSB     = 6;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit MIPS instruction word into its decode fields.
module instr_field_split
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output fields_t     fields
);

    always_comb begin
        fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
        fields.rs     = instr[RS_MSB:RS_LSB];
        fields.rt     = instr[RT_MSB:RT_LSB];
        fields.rd     = instr[RD_MSB:RD_LSB];
        fields.sa     = instr[SA_MSB:SA_LSB];
        fields.func   = instr[FUNC_MSB:FUNC_LSB];
        fields.imm    = instr[IMM_MSB:IMM_LSB];
        fields.target = instr[TARGET_MSB:TARGET_LSB];
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a two-entry skid buffer, valid/ready on both sides
// and synchronous flush. Optional decoded-field outputs under PIPE_DECODE_FIELDS_EN.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter int                 PC_W     = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pcadd4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pcadd4,
    output logic              out_bubble,
    output logic [1:0]        occupancy
`ifdef PIPE_DECODE_FIELDS_EN
    ,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        sa,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [25:0]       target
`endif
);

    state_e            state_q, state_nxt;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_instr_q, main_instr_nxt;
    logic [PC_W-1:0]   main_pc_q, main_pc_nxt;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_nxt;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_nxt;
    logic              push, pop;

    assign out_valid  = (state_q != EMPTY);
    assign out_bubble = (state_q == EMPTY);
    assign occupancy  = state_q;
    assign in_ready   = in_ready_q;
    assign out_instr  = main_instr_q;
    assign out_pcadd4 = main_pc_q;

    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt      = state_q;
        main_instr_nxt = main_instr_q;
        main_pc_nxt    = main_pc_q;
        skid_instr_nxt = skid_instr_q;
        skid_pc_nxt    = skid_pc_q;
        if (flush) begin
            // PC is deliberately held so decode still sees the last real PC+4.
            state_nxt      = EMPTY;
            main_instr_nxt = NOP_WORD;
        end else begin
            unique case (state_q)
                EMPTY: if (push) begin
                    state_nxt      = ONE;
                    main_instr_nxt = in_instr;
                    main_pc_nxt    = in_pcadd4;
                end
                ONE: begin
                    if (push && pop) begin
                        main_instr_nxt = in_instr;
                        main_pc_nxt    = in_pcadd4;
                    end else if (push) begin
                        state_nxt      = TWO;
                        skid_instr_nxt = in_instr;
                        skid_pc_nxt    = in_pcadd4;
                    end else if (pop) begin
                        state_nxt      = EMPTY;
                        main_instr_nxt = NOP_WORD;
                    end
                end
                TWO: if (pop) begin
                    state_nxt      = ONE;
                    main_instr_nxt = skid_instr_q;
                    main_pc_nxt    = skid_pc_q;
                end
                default: begin
                    state_nxt      = EMPTY;
                    main_instr_nxt = NOP_WORD;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: storage registers are reset too, so the bench and decode never observe X on the data outputs.
        if (Reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_instr_q <= NOP_WORD;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_nxt;
            in_ready_q   <= (state_nxt != TWO);
            main_instr_q <= main_instr_nxt;
            main_pc_q    <= main_pc_nxt;
            skid_instr_q <= skid_instr_nxt;
            skid_pc_q    <= skid_pc_nxt;
        end
    end

`ifdef PIPE_DECODE_FIELDS_EN
    fields_t fields_nxt, fields_q;

    if (DATA_W != 32) begin : g_width_check
        $error("PIPE_DECODE_FIELDS_EN requires DATA_W == 32");
    end

    instr_field_split u_field_split (
        .instr  (main_instr_nxt[31:0]),
        .fields (fields_nxt)
    );

    // Fields track main but read as zero for bubbles, independent of NOP_WORD.
    always_ff @(posedge Clk) begin
        if (Reset || state_nxt == EMPTY) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_nxt;
        end
    end

    assign opcode = fields_q.opcode;
    assign rs     = fields_q.rs;
    assign rt     = fields_q.rt;
    assign rd     = fields_q.rd;
    assign sa     = fields_q.sa;
    assign func   = fields_q.func;
    assign imm    = fields_q.imm;
    assign target = fields_q.target;
`endif

endmodule
